freq_meas_counter: RTL and testbench



---
 rtl/freq_meas_counter.sv | 138 +++++++++++++
 tb/tb_freq_meas_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_counter.sv
// Gated edge counter: counts synchronized rising edges of meas_in over a fixed
// window of refclk cycles and hands the count out through a valid/ready port.
module freq_meas_counter #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pll_locked,
  input  logic             meas_in,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             aborted,
  output logic             busy
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q;
  logic               rise;
  logic [GATE_W-1:0]  gate_cnt_q;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_q, ovf_d;
  logic               load_window;
  logic               finish_window;

  // Synchronizer and edge detector run in every state so a new window sees settled history
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Loss of lock wins over window completion, even in the final gate cycle
  always_comb begin
    state_d       = state_q;
    load_window   = 1'b0;
    finish_window = 1'b0;
    aborted       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && pll_locked) begin
          state_d     = GATE;
          load_window = 1'b1;
        end
      end
      GATE: begin
        if (!pll_locked) begin
          state_d = IDLE;
          aborted = 1'b1;
        end else if (gate_cnt_q == '0) begin
          state_d       = HOLD;
          finish_window = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) begin
          if (enable && pll_locked) begin
            state_d     = GATE;
            load_window = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q == GATE);
  assign result_valid = (state_q == HOLD);

  // The final cycle's rise is folded into the published count via edge_cnt_d
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load_window) begin
        gate_cnt_q <= GATE_LOAD;
        edge_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else if (state_q == GATE) begin
        gate_cnt_q <= gate_cnt_q - GATE_W'(1);
        edge_cnt_q <= edge_cnt_d;
        ovf_q      <= ovf_d;
      end
      if (finish_window) begin
        result   <= edge_cnt_d;
        overflow <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_counter.sv
// Scoreboard bench for freq_meas_counter: random input patterns checked against
// an edge-counting model, plus directed abort, back-pressure and reset scenarios.
module tb_freq_meas_counter;

  localparam int G     = 100;
  localparam int CW    = 5;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int SYNC  = 2;
  localparam int NWIN  = 6;
  localparam int PLEN  = NWIN * (G + 1);

  logic          refclk;
  logic          rst;
  logic          enable;
  logic          pll_locked;
  logic          meas_in;
  logic [CW-1:0] result;
  logic          overflow;
  logic          result_valid;
  logic          result_ready;
  logic          aborted;
  logic          busy;

  typedef struct {
    int   res;
    logic ovf;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   meas_period  = 0;
  int   meas_phase   = 0;
  logic pat [PLEN];

  freq_meas_counter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .enable      (enable),
    .pll_locked  (pll_locked),
    .meas_in     (meas_in),
    .result      (result),
    .overflow    (overflow),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .aborted     (aborted),
    .busy        (busy)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic patAt(input int m);
    if (m < 0 || m >= PLEN) return 1'b0;
    return pat[m];
  endfunction

  function automatic logic nextMeas();
    logic v;
    if (meas_period == 0) return 1'b0;
    v          = (meas_phase < meas_period / 2);
    meas_phase = (meas_phase + 1) % meas_period;
    return v;
  endfunction

  task automatic applyStimulus(input logic en, input logic lock, input logic rdy, input logic m);
    @(negedge refclk);
    enable       = en;
    pll_locked   = lock;
    result_ready = rdy;
    meas_in      = m;
  endtask

  task automatic step(input logic en, input logic lock, input logic rdy);
    applyStimulus(en, lock, rdy, nextMeas());
    #1;
  endtask

  task automatic setPeriod(input int p);
    meas_period = p;
    meas_phase  = 0;
    repeat (5) step(1'b0, 1'b1, 1'b1);
  endtask

  // A full window whose count is known in closed form, with enable dropped halfway
  task automatic runWindow(input int exp_res, input logic exp_ovf);
    sb_q.push_back('{res: exp_res, ovf: exp_ovf});
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= G; i++) begin
      step(i < 50, 1'b1, 1'b1);
      if (i == 1 || i == G) checkOutput("busy_in_gate", busy, 1);
      if (i == G) checkOutput("valid_during_gate", result_valid, 0);
    end
    step(1'b0, 1'b1, 1'b1);
    checkOutput("valid_in_hold", result_valid, 1);
    checkOutput("busy_in_hold", busy, 0);
    step(1'b0, 1'b1, 1'b1);
    checkOutput("valid_after_accept", result_valid, 0);
    checkOutput("busy_after_window", busy, 0);
  endtask

  // Monitor: every accepted result must match the oldest expectation
  initial begin
    forever begin
      @(negedge refclk);
      #2;
      if (!rst && result_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_result: got %0d, expected no result", result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("result", result, e.res);
          checkOutput("overflow", overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    int raw;
    int s;
    rst          = 1'b1;
    enable       = 1'b0;
    pll_locked   = 1'b0;
    meas_in      = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge refclk);
    #1;
    checkOutput("reset_result", result, 0);
    checkOutput("reset_valid", result_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_aborted", aborted, 0);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Random segments: noise, arbitrary square waves, constant levels
    for (int w = 0; w < NWIN; w++) begin
      int kind, p, ph;
      logic lvl;
      kind = $urandom_range(0, 2);
      p    = $urandom_range(2, 14);
      ph   = $urandom_range(0, 13);
      lvl  = 1'($urandom_range(0, 1));
      for (int k = w * (G + 1); k < (w + 1) * (G + 1); k++) begin
        case (kind)
          0:       pat[k] = 1'($urandom_range(0, 1));
          1:       pat[k] = (((k + ph) % p) < p / 2);
          default: pat[k] = lvl;
        endcase
      end
    end

    // Back-to-back windows start every G+1 cycles; a rising sample at index m
    // reaches the counter SYNC cycles later, so window w sees m in [s-1, s+G-2]
    for (int w = 0; w < NWIN; w++) begin
      s   = w * (G + 1);
      raw = 0;
      for (int m = s + 1 - SYNC; m <= s + G - SYNC; m++) begin
        if (patAt(m) && !patAt(m - 1)) raw++;
      end
      sb_q.push_back('{res: (raw > MAXC) ? MAXC : raw, ovf: (raw > MAXC)});
    end
    for (int k = 0; k < PLEN - 1; k++) applyStimulus(1'b1, 1'b1, 1'b1, pat[k]);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    #1;

    setPeriod(2);
    runWindow(MAXC, 1'b1);
    setPeriod(0);
    runWindow(0, 1'b0);
    setPeriod(10);
    runWindow(10, 1'b0);

    // Lock lost mid-window: one-cycle abort, no result, old result kept
    setPeriod(10);
    step(1'b1, 1'b1, 1'b1);
    repeat (50) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checkOutput("aborted_pulse", aborted, 1);
    step(1'b1, 1'b0, 1'b1);
    checkOutput("aborted_one_cycle", aborted, 0);
    checkOutput("busy_after_abort", busy, 0);
    checkOutput("valid_after_abort", result_valid, 0);
    checkOutput("result_retained", result, 10);
    setPeriod(4);
    runWindow(25, 1'b0);

    // Back-pressure: result held while ready is low
    setPeriod(5);
    sb_q.push_back('{res: 20, ovf: 1'b0});
    step(1'b1, 1'b1, 1'b0);
    repeat (G) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checkOutput("valid_held", result_valid, 1);
    repeat (20) step(1'b1, 1'b1, 1'b0);
    checkOutput("valid_still_held", result_valid, 1);
    checkOutput("busy_while_held", busy, 0);
    checkOutput("result_stable", result, 20);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    checkOutput("valid_after_ready_pulse", result_valid, 0);
    checkOutput("busy_restart", busy, 1);
    step(1'b0, 1'b0, 1'b1);
    checkOutput("aborted_second", aborted, 1);
    step(1'b0, 1'b1, 1'b1);
    checkOutput("result_after_second_abort", result, 20);

    // Asynchronous reset mid-gate
    setPeriod(10);
    step(1'b1, 1'b1, 1'b1);
    repeat (30) step(1'b1, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_gate_busy", busy, 0);
    checkOutput("rst_gate_result", result, 0);
    checkOutput("rst_gate_valid", result_valid, 0);
    checkOutput("rst_gate_overflow", overflow, 0);
    repeat (2) step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;

    // Asynchronous reset while a result is pending
    setPeriod(10);
    step(1'b1, 1'b1, 1'b0);
    repeat (G) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checkOutput("pending_valid", result_valid, 1);
    checkOutput("pending_result", result, 10);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_hold_valid", result_valid, 0);
    checkOutput("rst_hold_result", result, 0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    setPeriod(10);
    runWindow(10, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
